// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage buffer: occupancy states and
// the bit layout of the stage control word used by the CPU pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Control word field offsets shared by IF/ID, ID/EX, EX/MEM and MEM/WB.
    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_MEMREAD   = 1;
    localparam int unsigned CTRL_MEMWRITE  = 2;
    localparam int unsigned CTRL_ALUOP_LSB = 3;
    localparam int unsigned CTRL_ALUOP_W   = 4;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+control storage slot of a pipeline stage, with load/clear and a
// selectable active clock edge. Clear always zeroes control; data only when CLEAR_DATA.
module pipe_entry_reg #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned CTRL_W     = 16,
    parameter bit          NEG_EDGE   = 1'b1,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              activeClk;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    if (NEG_EDGE) begin : g_neg
        assign activeClk = ~clk_i;
    end else begin : g_pos
        assign activeClk = clk_i;
    end

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (clear_i) begin
            ctrl_d = '0;
            if (CLEAR_DATA) data_d = '0;
        end else if (load_i) begin
            data_d = data_i;
            ctrl_d = ctrl_i;
        end
    end

    always_ff @(posedge activeClk or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake, stall, flush-to-bubble
// and an optional second (skid) entry; also counts valid entries discarded by flush.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned DEPTH      = 2,
    parameter bit          FLUSH_DATA = 1'b1,
    parameter bit          NEG_EDGE   = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    state_e            state_q, state_d;
    logic              initDone_q;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W:0]    dropSum;
    logic              activeClk;
    logic              outValid, inReady, acc, pop;
    logic              headLoad;
    logic [1:0]        occ;
    logic [DATA_W-1:0] headDataD, headData, skidData;
    logic [CTRL_W-1:0] headCtrlD, headCtrl, skidCtrl;

    if (NEG_EDGE) begin : g_neg
        assign activeClk = ~clk_i;
    end else begin : g_pos
        assign activeClk = clk_i;
    end

    assign occ      = state_q;
    assign outValid = (state_q != ST_EMPTY);
    assign pop      = outValid & out_ready_i & ~stall_i;
    assign acc      = in_valid_i & inReady;

    // Single-entry stage must see the downstream pop to stream at full rate;
    // the skid variant only looks at its own state so there is no comb path.
    if (DEPTH == 1) begin : g_ready_comb
        assign inReady = initDone_q & (~outValid | (out_ready_i & ~stall_i));
    end else begin : g_ready_reg
        assign inReady = initDone_q & (state_q != ST_TWO);
    end

    always_comb begin
        state_d  = state_q;
        headLoad = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d  = ST_ONE;
                        headLoad = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        headLoad = 1'b1;
                    end else if (acc) begin
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d  = ST_ONE;
                        headLoad = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign headDataD = (state_q == ST_TWO) ? skidData : in_data_i;
    assign headCtrlD = (state_q == ST_TWO) ? skidCtrl : in_ctrl_i;

    pipe_entry_reg #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .NEG_EDGE  (NEG_EDGE),
        .CLEAR_DATA(FLUSH_DATA)
    ) u_head (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (headLoad),
        .clear_i(flush_i),
        .data_i (headDataD),
        .ctrl_i (headCtrlD),
        .data_o (headData),
        .ctrl_o (headCtrl)
    );

    if (DEPTH == 2) begin : g_skid
        logic skidLoad;
        assign skidLoad = ~flush_i & (state_q == ST_ONE) & acc & ~pop;

        pipe_entry_reg #(
            .DATA_W    (DATA_W),
            .CTRL_W    (CTRL_W),
            .NEG_EDGE  (NEG_EDGE),
            .CLEAR_DATA(FLUSH_DATA)
        ) u_skid (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load_i (skidLoad),
            .clear_i(flush_i),
            .data_i (in_data_i),
            .ctrl_i (in_ctrl_i),
            .data_o (skidData),
            .ctrl_o (skidCtrl)
        );
    end else begin : g_no_skid
        assign skidData = '0;
        assign skidCtrl = '0;
    end

    // A flush discards every held entry plus the one being accepted that edge.
    always_comb begin
        dropSum = {1'b0, drop_q} + (CNT_W+1)'(occ) + (CNT_W+1)'(acc);
        drop_d  = drop_q;
        if (flush_i) begin
            drop_d = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
        end
    end

    always_ff @(posedge activeClk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            initDone_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            initDone_q <= 1'b1;
            drop_q     <= drop_d;
        end
    end

    assign in_ready_o  = inReady;
    assign out_valid_o = outValid;
    assign out_data_o  = headData;
    assign out_ctrl_o  = outValid ? headCtrl : '0;
    assign occ_o       = occ;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: dutA is the default skid stage on the falling
// edge, dutB a single-register rising-edge stage with held data and a 4-bit drop counter.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        aFlush = 0, aStall = 0, aInValid = 0, aOutReady = 0;
    logic [63:0] aInData = '0;
    logic [15:0] aInCtrl = '0;
    logic        aInReady, aOutValid;
    logic [63:0] aOutData;
    logic [15:0] aOutCtrl;
    logic [1:0]  aOcc;
    logic [15:0] aDrop;

    logic        bFlush = 0, bStall = 0, bInValid = 0, bOutReady = 0;
    logic [63:0] bInData = '0;
    logic [15:0] bInCtrl = '0;
    logic        bInReady, bOutValid;
    logic [63:0] bOutData;
    logic [15:0] bOutCtrl;
    logic [1:0]  bOcc;
    logic [3:0]  bDrop;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] c;
    } entry_t;

    entry_t qA[$];
    entry_t qB[$];
    int checks = 0;
    int failures = 0;
    int popsA = 0;
    int popsB = 0;

    pipe_stage_buf dutA (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(aFlush), .stall_i(aStall),
        .in_valid_i(aInValid), .in_ready_o(aInReady), .in_data_i(aInData), .in_ctrl_i(aInCtrl),
        .out_valid_o(aOutValid), .out_ready_i(aOutReady), .out_data_o(aOutData),
        .out_ctrl_o(aOutCtrl), .occ_o(aOcc), .drop_cnt_o(aDrop)
    );

    pipe_stage_buf #(
        .DATA_W(64), .CTRL_W(16), .DEPTH(1), .FLUSH_DATA(1'b0), .NEG_EDGE(1'b0), .CNT_W(4)
    ) dutB (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(bFlush), .stall_i(bStall),
        .in_valid_i(bInValid), .in_ready_o(bInReady), .in_data_i(bInData), .in_ctrl_i(bInCtrl),
        .out_valid_o(bOutValid), .out_ready_i(bOutReady), .out_data_o(bOutData),
        .out_ctrl_o(bOutCtrl), .occ_o(bOcc), .drop_cnt_o(bDrop)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic flagUnexpectedPop(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=pop expected=no entry queued", name);
    endtask

    task automatic applyStimulus(input bit toB, input logic valid, input logic [63:0] data,
                                 input logic [15:0] ctrl, input logic outReady,
                                 input logic stall, input logic flush);
        if (!toB) begin
            aInValid = valid; aInData = data; aInCtrl = ctrl;
            aOutReady = outReady; aStall = stall; aFlush = flush;
        end else begin
            bInValid = valid; bInData = data; bInCtrl = ctrl;
            bOutReady = outReady; bStall = stall; bFlush = flush;
        end
    endtask

    task automatic tickA();
        @(negedge clk);
        #1;
    endtask

    task automatic tickB();
        @(posedge clk);
        #1;
    endtask

    // dutA changes state on the falling edge, so its handshake is sampled on the rising edge.
    initial begin : monA
        entry_t e;
        forever begin
            @(posedge clk);
            if (!rst_n || aFlush) begin
                qA.delete();
            end else begin
                if (aOutValid && aOutReady && !aStall) begin
                    popsA++;
                    if (qA.size() == 0) flagUnexpectedPop("A pop");
                    else begin
                        e = qA.pop_front();
                        checkOutput("A pop data", aOutData, e.d);
                        checkOutput("A pop ctrl", {48'd0, aOutCtrl}, {48'd0, e.c});
                    end
                end
                if (aInValid && aInReady) qA.push_back({aInData, aInCtrl});
            end
        end
    end

    initial begin : monB
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || bFlush) begin
                qB.delete();
            end else begin
                if (bOutValid && bOutReady && !bStall) begin
                    popsB++;
                    if (qB.size() == 0) flagUnexpectedPop("B pop");
                    else begin
                        e = qB.pop_front();
                        checkOutput("B pop data", bOutData, e.d);
                        checkOutput("B pop ctrl", {48'd0, bOutCtrl}, {48'd0, e.c});
                    end
                end
                if (bInValid && bInReady) qB.push_back({bInData, bInCtrl});
            end
        end
    end

    initial begin
        #12;
        checkOutput("reset A in_ready", aInReady, 0);
        checkOutput("reset A out_valid", aOutValid, 0);
        checkOutput("reset A occ", aOcc, 0);
        checkOutput("reset A drop", aDrop, 0);
        checkOutput("reset B in_ready", bInReady, 0);
        checkOutput("reset B out_valid", bOutValid, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tickA();
        checkOutput("A in_ready after release", aInReady, 1);

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1, 64'(i), 16'(i), 1, 0, 0);
            if (i > 1) checkOutput("A stream occ", aOcc, 1);
            tickA();
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tickA();
        checkOutput("A stream drained occ", aOcc, 0);

        // Backpressure into the skid entry
        applyStimulus(0, 1, 64'hA, 16'h0A0A, 0, 0, 0);
        tickA();
        applyStimulus(0, 1, 64'hB, 16'h0B0B, 0, 0, 0);
        tickA();
        applyStimulus(0, 1, 64'hC, 16'h0C0C, 0, 0, 0);
        checkOutput("A full occ", aOcc, 2);
        checkOutput("A full in_ready", aInReady, 0);
        tickA();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tickA();
        tickA();
        checkOutput("A backpressure drained occ", aOcc, 0);

        // Stall holds the head
        applyStimulus(0, 1, 64'hD00D, 16'h00FF, 0, 0, 0);
        tickA();
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("A stall data", aOutData, 64'hD00D);
            checkOutput("A stall ctrl", aOutCtrl, 16'h00FF);
            checkOutput("A stall occ", aOcc, 1);
            tickA();
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tickA();
        checkOutput("A stall released occ", aOcc, 0);

        // Flush with two held entries, then one held plus one accepted
        applyStimulus(0, 1, 64'hE1, 16'h1111, 0, 0, 0);
        tickA();
        applyStimulus(0, 1, 64'hE2, 16'h2222, 0, 0, 0);
        tickA();
        applyStimulus(0, 1, 64'hE3, 16'h3333, 0, 0, 1);
        tickA();
        checkOutput("A flush occ", aOcc, 0);
        checkOutput("A flush out_valid", aOutValid, 0);
        checkOutput("A flush ctrl", aOutCtrl, 0);
        checkOutput("A flush data zeroed", aOutData, 0);
        checkOutput("A flush drop two", aDrop, 2);
        applyStimulus(0, 1, 64'hE4, 16'h4444, 0, 0, 0);
        tickA();
        applyStimulus(0, 1, 64'hE5, 16'h5555, 0, 0, 1);
        tickA();
        checkOutput("A flush+acc drop", aDrop, 4);
        checkOutput("A flush+acc occ", aOcc, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while full
        applyStimulus(0, 1, 64'hF1, 16'h0F01, 0, 0, 0);
        tickA();
        applyStimulus(0, 1, 64'hF2, 16'h0F02, 0, 0, 0);
        tickA();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("A prereset occ", aOcc, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("A midreset out_valid", aOutValid, 0);
        checkOutput("A midreset ctrl", aOutCtrl, 0);
        checkOutput("A midreset data", aOutData, 0);
        checkOutput("A midreset occ", aOcc, 0);
        checkOutput("A midreset drop", aDrop, 0);
        checkOutput("A midreset in_ready", aInReady, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tickA();
        checkOutput("A rerelease in_ready", aInReady, 1);

        // Single-register stage: combinational ready, throughput, held data, saturation
        tickB();
        checkOutput("B empty in_ready", bInReady, 1);
        applyStimulus(1, 1, 64'h100, 16'h0100, 0, 0, 0);
        tickB();
        checkOutput("B full in_ready", bInReady, 0);
        checkOutput("B full occ", bOcc, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        #1 checkOutput("B ready follows out_ready", bInReady, 1);
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        #1 checkOutput("B ready blocked by stall", bInReady, 0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 1, 64'h200 + 64'(i), 16'(i), 1, 0, 0);
            #1;
            checkOutput("B stream occ", bOcc, 1);
            checkOutput("B stream in_ready", bInReady, 1);
            tickB();
        end
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        tickB();
        checkOutput("B drained occ", bOcc, 0);

        applyStimulus(1, 1, 64'h3C3C, 16'h00AA, 0, 0, 0);
        tickB();
        applyStimulus(1, 1, 64'h999, 16'h0055, 0, 0, 1);
        tickB();
        checkOutput("B flush out_valid", bOutValid, 0);
        checkOutput("B flush ctrl", bOutCtrl, 0);
        checkOutput("B flush data held", bOutData, 64'h3C3C);
        checkOutput("B flush drop", bDrop, 1);
        for (int i = 1; i <= 13; i++) begin
            applyStimulus(1, 1, 64'(i), 16'(i), 0, 0, 1);
            tickB();
        end
        checkOutput("B drop below max", bDrop, 14);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1, 1, 64'(i), 16'(i), 0, 0, 1);
            tickB();
        end
        checkOutput("B drop saturated", bDrop, 4'hF);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        tickB();
        tickB();

        checkOutput("A pop count", 64'(popsA), 11);
        checkOutput("B pop count", 64'(popsB), 7);
        checkOutput("A queue empty", 64'(qA.size()), 0);
        checkOutput("B queue empty", 64'(qB.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
